// File: rtl/uart_rx_param_if.sv
// Receiver-side bundle: the serial input plus the delivered word, strobe,
// error pulses and busy flag. The receiver uses the master view, the byte
// consumer the slave view.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 RX;
  logic [DATA_BITS-1:0] data_out;
  logic                 en_data_out;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  RX,
    output data_out,
    output en_data_out,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    output RX,
    input  data_out,
    input  en_data_out,
    input  parity_err,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable bit period, data width and parity.
// Validates the start bit at mid-bit, samples every following bit at its centre,
// and reports stop/parity errors as one-cycle pulses. After reset or a framing
// error the line must stay high for IDLE_BITS bit-times before a start is accepted.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 5000,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int IDLE_BITS    = 12
) (
  input logic             clk,
  input logic             res,
  uart_rx_param_if.master bus
);

  localparam int IDLE_CNT = CLKS_PER_BIT * IDLE_BITS;
  localparam int CNT_W    = $clog2(IDLE_CNT + 1);
  localparam int HALF     = CLKS_PER_BIT / 2;
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    PAR_BIT,
    STOP
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     bit_idx, idx_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [DATA_BITS-1:0] data_q, data_n;
  logic                 perr_q, perr_n;
  logic                 busy_q, busy_n;
  logic                 en_q, en_n;
  logic                 pe_q, pe_n;
  logic                 fe_q, fe_n;
  logic                 rx_meta, rx_s, rx_d;
  logic                 exp_par;

  // Odd mode expects the bit that makes the total count of ones odd.
  assign exp_par = (PARITY == 1) ? ~^shift_q : ^shift_q;

  // Two-flop synchroniser for the pad input plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= bus.RX;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state   <= WAIT_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift_q <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= idx_n;
      shift_q <= shift_n;
      data_q  <= data_n;
      perr_q  <= perr_n;
      busy_q  <= busy_n;
      en_q    <= en_n;
      pe_q    <= pe_n;
      fe_q    <= fe_n;
    end
  end

  // Next-state logic: bit timing, sampling and end-of-frame decisions.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = bit_idx;
    shift_n = shift_q;
    data_n  = data_q;
    perr_n  = perr_q;
    busy_n  = busy_q;
    en_n    = 1'b0;
    pe_n    = 1'b0;
    fe_n    = 1'b0;

    case (state)
      WAIT_IDLE: begin
        busy_n = 1'b0;
        if (!rx_s) begin
          cnt_n = '0;
        end else if (cnt == IDLE_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      IDLE: begin
        busy_n = 1'b0;
        cnt_n  = '0;
        if (rx_d && !rx_s) begin
          state_n = START;
          busy_n  = 1'b1;
        end
      end

      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end else begin
            state_n = DATA;
            idx_n   = '0;
            perr_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) begin
            state_n = (PARITY != 0) ? PAR_BIT : STOP;
          end else begin
            idx_n = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      PAR_BIT: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          perr_n  = (rx_s != exp_par);
          state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n  = '0;
          busy_n = 1'b0;
          if (rx_s) begin
            state_n = IDLE;
            if (perr_q) begin
              pe_n = 1'b1;
            end else begin
              en_n   = 1'b1;
              data_n = shift_q;
            end
          end else begin
            state_n = WAIT_IDLE;
            fe_n    = 1'b1;
            pe_n    = perr_q;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n = WAIT_IDLE;
        cnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.data_out    = data_q;
  assign bus.en_data_out = en_q;
  assign bus.parity_err  = pe_q;
  assign bus.frame_err   = fe_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: one 8N1 receiver and one even-parity receiver,
// both at 16 clocks per bit. Every frame sent pushes its expected outcome
// (strobe/parity error/frame error, data, arrival cycle) onto a per-receiver
// queue; a negedge monitor pops and compares whenever a receiver pulses.
module tb_uart_rx_param;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic clk;
  logic res;
  int   pcyc     = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  uart_rx_param_if #(.DATA_BITS(8)) bus_a ();
  uart_rx_param_if #(.DATA_BITS(8)) bus_b ();

  uart_rx_param #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .PARITY      (0),
    .IDLE_BITS   (12)
  ) dut_a (
    .clk(clk),
    .res(res),
    .bus(bus_a)
  );

  uart_rx_param #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .PARITY      (2),
    .IDLE_BITS   (12)
  ) dut_b (
    .clk(clk),
    .res(res),
    .bus(bus_b)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Posedge counter used to timestamp expected and observed events.
  initial forever @(posedge clk) pcyc <= pcyc + 1;

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_line(input bit to_b, input logic v);
    if (to_b) bus_b.RX = v;
    else      bus_a.RX = v;
  endtask

  // Sends one frame starting at the current negedge; exp_kind <0 means no outcome expected.
  task automatic apply_stimulus(input bit to_b, input logic [7:0] data, input bit has_par,
                                input logic par_bit, input logic stop_bit, input int exp_kind);
    int          p0;
    int          nb;
    logic [10:0] bits;
    exp_t        e;
    p0 = pcyc;
    if (has_par) begin
      nb   = 11;
      bits = {stop_bit, par_bit, data, 1'b0};
    end else begin
      nb   = 10;
      bits = {1'b0, stop_bit, data, 1'b0};
    end
    if (exp_kind >= 0) begin
      e.kind = exp_kind;
      e.data = data;
      e.due  = p0 + 3 + HALF + (nb - 1) * CPB;
      if (to_b) q_b.push_back(e);
      else      q_a.push_back(e);
    end
    for (int i = 0; i < nb; i++) begin
      drive_line(to_b, bits[i]);
      repeat (CPB) @(negedge clk);
    end
  endtask

  // Compares any pulse from one receiver against the head of its queue.
  task automatic scan(input bit is_b);
    logic       en, pe, fe;
    logic [7:0] d;
    int         sz;
    int         kind;
    exp_t       e;
    string      nm;
    nm = is_b ? "b" : "a";
    if (is_b) begin
      en = bus_b.en_data_out; pe = bus_b.parity_err; fe = bus_b.frame_err;
      d  = bus_b.data_out;    sz = q_b.size();
    end else begin
      en = bus_a.en_data_out; pe = bus_a.parity_err; fe = bus_a.frame_err;
      d  = bus_a.data_out;    sz = q_a.size();
    end
    if (en || pe || fe) begin
      check_output({nm, "_onehot"}, 32'($countones({en, pe, fe})), 32'd1);
      if (sz == 0) begin
        check_output({nm, "_unexpected_event"}, {29'd0, fe, pe, en}, 32'd0);
      end else begin
        if (is_b) e = q_b.pop_front();
        else      e = q_a.pop_front();
        kind = fe ? 2 : (pe ? 1 : 0);
        check_output({nm, "_kind"}, 32'(kind), 32'(e.kind));
        check_output({nm, "_cycle"}, 32'(pcyc), 32'(e.due));
        if (e.kind == 0) check_output({nm, "_data"}, {24'd0, d}, {24'd0, e.data});
      end
    end else if (sz > 0) begin
      e = is_b ? q_b[0] : q_a[0];
      if (pcyc > e.due) begin
        check_output({nm, "_missed_event"}, 32'(pcyc), 32'(e.due));
        if (is_b) void'(q_b.pop_front());
        else      void'(q_a.pop_front());
      end
    end
  endtask

  // Output monitor, sampling on the falling edge.
  initial forever begin
    @(negedge clk);
    if (res === 1'b1) begin
      scan(1'b0);
      scan(1'b1);
    end
  end

  // Directed sequence.
  initial begin
    res      = 1'b0;
    bus_a.RX = 1'b1;
    bus_b.RX = 1'b1;
    repeat (3) @(negedge clk);
    check_output("rst_a_data", {24'd0, bus_a.data_out}, 32'd0);
    check_output("rst_a_en",   {31'd0, bus_a.en_data_out}, 32'd0);
    check_output("rst_a_pe",   {31'd0, bus_a.parity_err}, 32'd0);
    check_output("rst_a_fe",   {31'd0, bus_a.frame_err}, 32'd0);
    check_output("rst_a_busy", {31'd0, bus_a.busy}, 32'd0);
    check_output("rst_b_data", {24'd0, bus_b.data_out}, 32'd0);
    check_output("rst_b_busy", {31'd0, bus_b.busy}, 32'd0);
    res = 1'b1;
    repeat (200) @(negedge clk);

    $display("[TB] 8N1 single frame");
    apply_stimulus(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 0);

    $display("[TB] back-to-back frames");
    apply_stimulus(1'b0, 8'h26, 1'b0, 1'b0, 1'b1, 0);
    apply_stimulus(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, 0);
    repeat (20) @(negedge clk);
    check_output("a_hold", {24'd0, bus_a.data_out}, 32'h0000_00AA);

    $display("[TB] false start");
    bus_a.RX = 1'b0;
    repeat (3) @(negedge clk);
    bus_a.RX = 1'b1;
    repeat (2) @(negedge clk);
    check_output("a_false_busy_hi", {31'd0, bus_a.busy}, 32'd1);
    repeat (7) @(negedge clk);
    check_output("a_false_busy_lo", {31'd0, bus_a.busy}, 32'd0);
    repeat (20) @(negedge clk);
    apply_stimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 0);

    $display("[TB] even parity");
    apply_stimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 0);
    apply_stimulus(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 1);
    repeat (5) @(negedge clk);
    check_output("b_hold_after_pe", {24'd0, bus_b.data_out}, 32'h0000_005A);
    apply_stimulus(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 0);

    $display("[TB] framing error");
    apply_stimulus(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 2);
    bus_a.RX = 1'b1;
    repeat (5) @(negedge clk);
    check_output("a_hold_after_fe", {24'd0, bus_a.data_out}, 32'h0000_003C);
    repeat (100) @(negedge clk);
    apply_stimulus(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, -1);
    repeat (200) @(negedge clk);
    apply_stimulus(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 0);

    $display("[TB] reset mid-frame");
    bus_a.RX = 1'b0;
    repeat (CPB) @(negedge clk);
    bus_a.RX = 1'b1;
    repeat (CPB) @(negedge clk);
    bus_a.RX = 1'b1;
    repeat (CPB) @(negedge clk);
    bus_a.RX = 1'b0;
    repeat (CPB) @(negedge clk);
    bus_a.RX = 1'b0;
    repeat (8) @(negedge clk);
    res = 1'b0;
    #1;
    check_output("a_abort_data", {24'd0, bus_a.data_out}, 32'd0);
    check_output("a_abort_busy", {31'd0, bus_a.busy}, 32'd0);
    check_output("b_abort_data", {24'd0, bus_b.data_out}, 32'd0);
    bus_a.RX = 1'b1;
    repeat (5) @(negedge clk);
    res = 1'b1;
    repeat (20) @(negedge clk);
    apply_stimulus(1'b0, 8'h33, 1'b0, 1'b0, 1'b1, -1);
    repeat (200) @(negedge clk);
    apply_stimulus(1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, 0);
    repeat (30) @(negedge clk);

    check_output("a_queue_empty", 32'(q_a.size()), 32'd0);
    check_output("b_queue_empty", 32'(q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
